multi_wave_gen: RTL and testbench

//  Parametrised, multi-mode audio waveform generator for the synth voice path.

---
 rtl/multi_wave_pkg.sv | 13 +
 rtl/wave_shaper.sv | 33 +++
 rtl/multi_wave_gen.sv | 148 ++++++++++++++
 tb/tb_multi_wave_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_wave_pkg.sv
// rtl/multi_wave_pkg.sv - shared types and constants for the multi-mode waveform generator
package multi_wave_pkg;

    typedef enum logic [1:0] {
        WM_TRI = 2'd0,
        WM_SAW = 2'd1,
        WM_SQR = 2'd2,
        WM_PUL = 2'd3
    } wave_mode_e;

    localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/wave_shaper.sv
// rtl/wave_shaper.sv - maps a phase index to a signed, full-scale sample for the selected shape
module wave_shaper
    import multi_wave_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] p_i,
    input  wave_mode_e            mode_i,
    input  logic [ADDR_WIDTH-1:0] duty_i,
    output logic [DATA_WIDTH-1:0] s_o
);

    logic [ADDR_WIDTH-1:0] u;

    always_comb begin
        u = '0;
        case (mode_i)
            WM_TRI: u = p_i[ADDR_WIDTH-1] ? ~{p_i[ADDR_WIDTH-2:0], 1'b0}
                                          :  {p_i[ADDR_WIDTH-2:0], 1'b0};
            WM_SAW: u = p_i;
            WM_SQR: u = p_i[ADDR_WIDTH-1] ? '0 : '1;
            WM_PUL: u = (p_i < duty_i) ? '1 : '0;
        endcase
    end

    // Offset-binary to two's complement, placed in the top bits of the sample word.
    always_comb begin
        s_o = '0;
        s_o[DATA_WIDTH-1 -: ADDR_WIDTH] = {~u[ADDR_WIDTH-1], u[ADDR_WIDTH-2:0]};
    end

endmodule

// File: rtl/multi_wave_gen.sv
// rtl/multi_wave_gen.sv - phase-accumulator oscillator with deferred config and a 3-stage output pipeline
module multi_wave_gen
    import multi_wave_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 24,
    parameter int ADDR_WIDTH  = 8,
    parameter int AMP_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_en,
    input  logic                   sync_rst,
    input  logic                   cfg_load,
    input  logic [PHASE_WIDTH-1:0] ftw,
    input  logic [1:0]             mode,
    input  logic [ADDR_WIDTH-1:0]  duty,
    input  logic [AMP_WIDTH-1:0]   amp,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   wrap,
    output logic                   cfg_pend
);

    localparam logic [ADDR_WIDTH-1:0] DUTY_RST = ADDR_WIDTH'(1) << (ADDR_WIDTH - 1);

    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] ftw_act_q, ftw_sh_q;
    wave_mode_e             mode_act_q, mode_sh_q;
    logic [ADDR_WIDTH-1:0]  duty_act_q, duty_sh_q;
    logic [AMP_WIDTH-1:0]   amp_act_q, amp_sh_q;
    logic                   cfg_pend_q;

    logic                   v1_q, v2_q;
    logic [ADDR_WIDTH-1:0]  p1_q;
    wave_mode_e             mode1_q;
    logic [ADDR_WIDTH-1:0]  duty1_q;
    logic [AMP_WIDTH-1:0]   amp1_q, amp2_q;
    logic [DATA_WIDTH-1:0]  s2_q;
    logic [DATA_WIDTH-1:0]  dout_q;
    logic                   dout_valid_q, wrap_q;

    logic [PHASE_WIDTH:0]            sum;
    logic                            carry, apply;
    logic [ADDR_WIDTH-1:0]           p_d;
    logic [DATA_WIDTH-1:0]           s_d;
    logic signed [DATA_WIDTH+AMP_WIDTH:0] prod, scaled;

    assign sum   = {1'b0, acc_q} + {1'b0, ftw_act_q};
    assign carry = sum[PHASE_WIDTH];
    // Shadow is promoted only at a phase wrap or hard sync so the waveform never glitches mid-period.
    assign apply = cfg_pend_q && (sync_rst || (sample_en && carry));

    always_comb begin
        acc_d = acc_q;
        p_d   = acc_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
        if (sync_rst) begin
            acc_d = '0;
            p_d   = '0;
        end else if (sample_en) begin
            acc_d = sum[PHASE_WIDTH-1:0];
        end
    end

    wave_shaper #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_shaper (
        .p_i    (p1_q),
        .mode_i (mode1_q),
        .duty_i (duty1_q),
        .s_o    (s_d)
    );

    assign prod   = $signed(s2_q) * $signed({1'b0, amp2_q});
    assign scaled = prod >>> AMP_WIDTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            ftw_act_q    <= '0;
            mode_act_q   <= WM_TRI;
            duty_act_q   <= DUTY_RST;
            amp_act_q    <= '1;
            ftw_sh_q     <= '0;
            mode_sh_q    <= WM_TRI;
            duty_sh_q    <= DUTY_RST;
            amp_sh_q     <= '1;
            cfg_pend_q   <= 1'b0;
            v1_q         <= 1'b0;
            p1_q         <= '0;
            mode1_q      <= WM_TRI;
            duty1_q      <= '0;
            amp1_q       <= '0;
            v2_q         <= 1'b0;
            s2_q         <= '0;
            amp2_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wrap_q <= sample_en && !sync_rst && carry;

            if (apply) begin
                ftw_act_q  <= ftw_sh_q;
                mode_act_q <= mode_sh_q;
                duty_act_q <= duty_sh_q;
                amp_act_q  <= amp_sh_q;
            end
            // A load coinciding with apply keeps the new values pending behind the old shadow.
            if (cfg_load) begin
                ftw_sh_q   <= ftw;
                mode_sh_q  <= wave_mode_e'(mode);
                duty_sh_q  <= duty;
                amp_sh_q   <= amp;
                cfg_pend_q <= 1'b1;
            end else if (apply) begin
                cfg_pend_q <= 1'b0;
            end

            v1_q <= sample_en;
            if (sample_en) begin
                p1_q    <= p_d;
                mode1_q <= mode_act_q;
                duty1_q <= duty_act_q;
                amp1_q  <= amp_act_q;
            end

            v2_q <= v1_q;
            if (v1_q) begin
                s2_q   <= s_d;
                amp2_q <= amp1_q;
            end

            dout_valid_q <= v2_q;
            if (v2_q) begin
                dout_q <= scaled[DATA_WIDTH-1:0];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign wrap       = wrap_q;
    assign cfg_pend   = cfg_pend_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// tb/tb_multi_wave_gen.sv - directed vector and sequence bench for multi_wave_gen
module tb_multi_wave_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic        sync_rst = 1'b0;
    logic        cfg_load = 1'b0;
    logic [23:0] ftw = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  duty = '0;
    logic [7:0]  amp = '0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        wrap;
    logic        cfg_pend;

    int total = 0;
    int bad = 0;
    int wrap_cnt = 0;
    logic [15:0] got[$];

    multi_wave_gen #(
        .DATA_WIDTH(16), .PHASE_WIDTH(24), .ADDR_WIDTH(8), .AMP_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sync_rst(sync_rst),
        .cfg_load(cfg_load), .ftw(ftw), .mode(mode), .duty(duty), .amp(amp),
        .dout(dout), .dout_valid(dout_valid), .wrap(wrap), .cfg_pend(cfg_pend)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_valid) got.push_back(dout);
        if (wrap) wrap_cnt++;
    end

    typedef struct {
        logic [23:0] ftw;
        logic [1:0]  mode;
        logic [7:0]  duty;
        logic [7:0]  amp;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_cfg(input logic [23:0] f, input logic [1:0] m,
                             input logic [7:0] d, input logic [7:0] a);
        ftw = f; mode = m; duty = d; amp = a;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
    endtask

    task automatic load_only(input logic [23:0] f, input logic [1:0] m,
                             input logic [7:0] d, input logic [7:0] a);
        ftw = f; mode = m; duty = d; amp = a;
        cfg_load = 1'b1;
    endtask

    initial begin
        int errs;
        vecs[0]  = '{24'h400000, 2'd0, 8'h80, 8'hFF, 16'h0000};
        vecs[1]  = '{24'h800000, 2'd0, 8'h80, 8'hFF, 16'h7E81};
        vecs[2]  = '{24'h200000, 2'd0, 8'h80, 8'hFF, 16'hC040};
        vecs[3]  = '{24'hC00000, 2'd1, 8'h80, 8'hFF, 16'h3FC0};
        vecs[4]  = '{24'h010000, 2'd1, 8'h80, 8'h80, 16'hC080};
        vecs[5]  = '{24'h7F0000, 2'd2, 8'h80, 8'hFF, 16'h7E81};
        vecs[6]  = '{24'h800000, 2'd2, 8'h80, 8'hFF, 16'h8080};
        vecs[7]  = '{24'h3F0000, 2'd3, 8'h40, 8'hFF, 16'h7E81};
        vecs[8]  = '{24'h400000, 2'd3, 8'h40, 8'hFF, 16'h8080};
        vecs[9]  = '{24'h000000, 2'd3, 8'h00, 8'hFF, 16'h8080};
        vecs[10] = '{24'h000000, 2'd1, 8'h80, 8'h00, 16'h0000};
        vecs[11] = '{24'h7F0000, 2'd1, 8'h80, 8'h01, 16'hFFFF};
        vecs[12] = '{24'h000000, 2'd0, 8'h80, 8'hFF, 16'h8080};

        // Reset idle
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_dout_%0d", i), 32'(dout), 32'h0);
            chk($sformatf("idle_valid_%0d", i), 32'(dout_valid), 32'h0);
            chk($sformatf("idle_wrap_%0d", i), 32'(wrap), 32'h0);
        end
        chk("idle_cfg_pend", 32'(cfg_pend), 32'h0);
        tick();

        // Latency of a single sample
        apply_cfg(24'h010000, 2'd0, 8'h80, 8'hFF);
        chk("cfg_applied_by_sync", 32'(cfg_pend), 32'h0);
        got.delete();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        @(negedge clk); chk("lat_e1_valid", 32'(dout_valid), 32'h0);
        @(negedge clk); chk("lat_e2_valid", 32'(dout_valid), 32'h0);
        @(negedge clk); chk("lat_e3_valid", 32'(dout_valid), 32'h1);
        chk("lat_e3_dout", 32'(dout), 32'h8080);
        @(negedge clk); chk("lat_e4_valid", 32'(dout_valid), 32'h0);
        chk("lat_hold_dout", 32'(dout), 32'h8080);
        tick();

        // Table vectors: second sample after sync lands on p = ftw[23:16]
        foreach (vecs[k]) begin
            apply_cfg(vecs[k].ftw, vecs[k].mode, vecs[k].duty, vecs[k].amp);
            got.delete();
            sample_en = 1'b1;
            tick(); tick();
            sample_en = 1'b0;
            repeat (5) tick();
            chk($sformatf("vec%0d_count", k), 32'(got.size()), 32'd2);
            if (got.size() == 2) chk($sformatf("vec%0d_dout", k), 32'(got[1]), 32'(vecs[k].exp));
        end

        // Full triangle period, back-to-back
        apply_cfg(24'h010000, 2'd0, 8'h80, 8'hFF);
        got.delete(); wrap_cnt = 0;
        sample_en = 1'b1;
        repeat (256) tick();
        sample_en = 1'b0;
        repeat (5) tick();
        chk("tri_count", 32'(got.size()), 32'd256);
        chk("tri_wraps", 32'(wrap_cnt), 32'd1);
        if (got.size() == 256) begin
            chk("tri_p0", 32'(got[0]), 32'h8080);
            chk("tri_p64", 32'(got[64]), 32'h0000);
            chk("tri_p128", 32'(got[128]), 32'h7E81);
            chk("tri_p255", 32'(got[255]), 32'h817F);
        end

        // Pulse duty 0x40 over two periods, then duty 0
        apply_cfg(24'h010000, 2'd3, 8'h40, 8'hFF);
        got.delete(); wrap_cnt = 0;
        sample_en = 1'b1;
        repeat (512) tick();
        sample_en = 1'b0;
        repeat (5) tick();
        errs = 0;
        for (int j = 0; j < got.size(); j++)
            if (got[j] !== (((j % 256) < 64) ? 16'h7E81 : 16'h8080)) errs++;
        chk("pulse_count", 32'(got.size()), 32'd512);
        chk("pulse_bad_samples", 32'(errs), 32'd0);
        chk("pulse_wraps", 32'(wrap_cnt), 32'd2);

        apply_cfg(24'h010000, 2'd3, 8'h00, 8'hFF);
        got.delete();
        sample_en = 1'b1;
        repeat (64) tick();
        sample_en = 1'b0;
        repeat (5) tick();
        errs = 0;
        foreach (got[j]) if (got[j] !== 16'h8080) errs++;
        chk("duty0_count", 32'(got.size()), 32'd64);
        chk("duty0_bad_samples", 32'(errs), 32'd0);

        // Mid-period load waits for the wrap; a load on the wrap cycle stays pending
        apply_cfg(24'h010000, 2'd0, 8'h80, 8'hFF);
        got.delete();
        for (int j = 0; j < 260; j++) begin
            if (j == 11) chk("mid_pend_after_load", 32'(cfg_pend), 32'h1);
            if (j == 200) chk("mid_pend_still", 32'(cfg_pend), 32'h1);
            if (j == 10) load_only(24'h010000, 2'd1, 8'h80, 8'hFF);
            if (j == 255) load_only(24'h010000, 2'd2, 8'h80, 8'hFF);
            sample_en = 1'b1;
            tick();
            cfg_load = 1'b0;
        end
        sample_en = 1'b0;
        repeat (5) tick();
        chk("mid_pend_wrap_load", 32'(cfg_pend), 32'h1);
        chk("mid_count", 32'(got.size()), 32'd260);
        if (got.size() == 260) begin
            chk("mid_tri_p100", 32'(got[100]), 32'h47B8);
            chk("mid_tri_p254", 32'(got[254]), 32'h837D);
            chk("mid_tri_wrap_sample", 32'(got[255]), 32'h817F);
            chk("mid_saw_p2", 32'(got[258]), 32'h827E);
        end

        // sync_rst together with sample_en at acc = 0x7F0000
        apply_cfg(24'h010000, 2'd0, 8'h80, 8'hFF);
        got.delete();
        sample_en = 1'b1;
        repeat (127) tick();
        sample_en = 1'b0;
        load_only(24'h010000, 2'd1, 8'h80, 8'hFF);
        tick();
        cfg_load = 1'b0;
        chk("sync_pend_before", 32'(cfg_pend), 32'h1);
        sync_rst = 1'b1; sample_en = 1'b1;
        tick();
        sync_rst = 1'b0;
        chk("sync_wrap", 32'(wrap), 32'h0);
        chk("sync_pend_after", 32'(cfg_pend), 32'h0);
        tick(); tick();
        sample_en = 1'b0;
        repeat (5) tick();
        chk("sync_count", 32'(got.size()), 32'd130);
        if (got.size() == 130) begin
            chk("sync_emit_p0", 32'(got[127]), 32'h8080);
            chk("sync_next_p0_saw", 32'(got[128]), 32'h8080);
            chk("sync_next_p1_saw", 32'(got[129]), 32'h817F);
        end

        // Asynchronous reset with two samples in flight
        apply_cfg(24'h400000, 2'd2, 8'h80, 8'hFF);
        got.delete();
        sample_en = 1'b1;
        tick(); tick();
        sample_en = 1'b0;
        chk("pre_rst_dout_nonzero", 32'(dout != 16'h0), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_pend", 32'(cfg_pend), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("rst_no_stray_valid", 32'(got.size()), 32'd0);
        chk("rst_dout_after", 32'(dout), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
